cube_color_controller: RTL and testbench
========================================

// Module: cube_color_controller
// PURPOSE
//   Sequences the 28-cube top-colour map for one level. Converts Q*bert landings (done_move + one-hot
//   position_qb from the map's landing boxes) into the per-cube colour vector driving the map renderer's
//   e_color_state, counts coloured cubes, detects level completion, flashes the pyramid, then clears it.
//   Sits between qbert_layer/map outputs and the map colour input; NIOS sees status through ctrl_state.
// PARAMETERS
//   N_CUBE      28          number of cubes / width of position and colour vectors
//   WIN_CYCLES  33_000_000  CLK_33 cycles spent in WIN (1 s flash)
//   FLASH_DIV   4_125_000   cycles per flash half-period in WIN
// PORTS
//   CLK_33       in   1       33 MHz pixel/system clock, single clock domain
//   reset        in   1       asynchronous, active-high; clears all state
//   e_start_qb   in   1       NIOS start/restart level (level pulse, sampled each cycle)
//   e_pause_qb   in   1       NIOS pause (level)
//   e_mode       in   1       0 = landing colours cube; 1 = landing toggles cube colour
//   done_move    in   1       one-cycle pulse: Q*bert landed
//   position_qb  in   N_CUBE  one-hot landing box, valid in the done_move cycle
//   color_state  out  N_CUBE  bit i = 1: cube i top shown in target colour
//   n_colored    out  5       number of set bits in color_state (0..28)
//   level_win    out  1       one-cycle pulse on entry to WIN
//   flash        out  1       toggling flash enable, 0 outside WIN
//   bad_pos      out  1       one-cycle pulse: landing with zero or multi-hot position_qb
//   ctrl_state   out  3       current FSM state encoding
// BEHAVIOUR
//   Reset values: color_state=0, n_colored=0, level_win=0, flash=0, bad_pos=0, state IDLE(0).
//   FSM: IDLE(0) PLAY(1) EVAL(2) CHECK(3) WIN(4) CLEAR(5); all outputs registered.
//   IDLE : e_start_qb -> CLEAR-on-entry semantics: color_state<=0, n_colored<=0, go PLAY.
//   PLAY : done_move & !e_pause_qb -> latch position_qb into pos_q, go EVAL. done_move while paused
//          is dropped. e_start_qb (priority over done_move) clears colours/count, stays PLAY.
//   EVAL : pos_q one-hot -> mode 0: set bit (count+1 only if bit was 0); mode 1: toggle bit (count +/-1).
//          pos_q zero or multi-hot -> no update, bad_pos=1 for that cycle. Always -> CHECK.
//   CHECK: n_colored==N_CUBE -> WIN with level_win=1 for one cycle; else PLAY.
//   Latency: done_move at cycle T -> color_state/n_colored updated at edge ending T+1 (visible T+2);
//          level_win visible T+3. done_move in EVAL/CHECK is ignored (jumps last >> 3 cycles).
//   WIN  : 32-bit hold counter and flash divider count only while !e_pause_qb; flash toggles every
//          FLASH_DIV cycles starting at 1; e_start_qb ignored. Hold counter == WIN_CYCLES-1 -> CLEAR.
//   CLEAR: color_state<=0, n_colored<=0, flash<=0, counters<=0, -> IDLE (one cycle).
//   Mode 0 landing on an already-coloured cube: no change, no count change.
//   n_colored never wraps: increment only from <N_CUBE, decrement only from >0 (guaranteed by bit state).
//   e_mode sampled in EVAL; changing it mid-level affects subsequent landings only.
//   Reset mid-operation (any state): immediate return to reset values, no pulse outputs emitted.
// STRUCTURE
//   qbert_pkg: ctrl_state_t enum (IDLE..CLEAR, 3-bit), localparam N_CUBE_DEF=28, CNT_W=5.
//   Sub-module onehot_check (N-bit in -> is_onehot, is_zero), combinational, used in EVAL.
//   Single always_ff (async reset) for FSM + datapath; no other sub-modules.
// TESTING  (bench overrides WIN_CYCLES=20, FLASH_DIV=4)
//   start, done_move with position_qb=28'h1 (mode 0) -> color_state=28'h1, n_colored=1 two cycles later.
//   same landing again mode 0 -> no change; e_mode=1 landing on bit 5 twice -> bit5 1 then 0, count 1->2->1.
//   landing with position_qb=0 and with 28'h3 -> bad_pos pulse each, color_state unchanged.
//   land on all 28 cubes -> level_win single pulse, flash toggles every 4 cycles, 20 cycles later
//     color_state=0, n_colored=0, ctrl_state=IDLE; with e_pause_qb high in WIN the count freezes.
//   done_move while e_pause_qb=1 -> ignored; e_start_qb same cycle as done_move in PLAY -> cleared only.
//   assert reset during WIN at count 10 -> all outputs 0, ctrl_state=0 next cycle, no level_win.

Source files
------------

// File: rtl/qbert_pkg.sv
// qbert_pkg: shared types and constants for the Q*bert cube colour controller.
//   ctrl_state_t : controller FSM state encoding, exported to NIOS via ctrl_state
//   N_CUBE_DEF   : default number of cubes in the pyramid
//   CNT_W        : width of the coloured-cube counter (holds 0..28)
package qbert_pkg;

  localparam int N_CUBE_DEF = 28;
  localparam int CNT_W      = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    EVAL  = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    CLEAR = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/cube_color_controller_onehot_check.sv
// onehot_check: combinational classifier for a landing-position vector.
//   vec       in  N  position vector to classify
//   is_onehot out 1  exactly one bit of vec is set
//   is_zero   out 1  no bit of vec is set
module onehot_check #(
  parameter int N = 28
) (
  input  logic [N-1:0] vec,
  output logic         is_onehot,
  output logic         is_zero
);

  // seen[i]  : some bit in vec[i:0] is set
  // multi[i] : at least two bits in vec[i:0] are set
  logic [N-1:0] seen;
  logic [N-1:0] multi;

  assign seen[0]  = vec[0];
  assign multi[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_scan
      assign seen[gi]  = seen[gi-1] | vec[gi];
      assign multi[gi] = multi[gi-1] | (seen[gi-1] & vec[gi]);
    end
  endgenerate

  assign is_zero   = ~seen[N-1];
  assign is_onehot = seen[N-1] & ~multi[N-1];

endmodule

// File: rtl/cube_color_controller.sv
// cube_color_controller: sequences the per-cube top-colour map for one level.
// Turns Q*bert landings into the colour vector for the map renderer, counts
// coloured cubes, detects level completion, flashes the pyramid, then clears.
//   CLK_33      in   1       system clock
//   reset       in   1       asynchronous active-high reset
//   e_start_qb  in   1       start / restart level
//   e_pause_qb  in   1       pause (freezes landings and the WIN timer)
//   e_mode      in   1       0: landing colours cube, 1: landing toggles cube
//   done_move   in   1       one-cycle landing pulse
//   position_qb in   N_CUBE  one-hot landing cube, valid with done_move
//   color_state out  N_CUBE  bit i set: cube i shown in target colour
//   n_colored   out  CNT_W   number of set bits in color_state
//   level_win   out  1       one-cycle pulse on entry to WIN
//   flash       out  1       flash enable, toggling during WIN only
//   bad_pos     out  1       one-cycle pulse for a zero / multi-hot landing
//   ctrl_state  out  3       current FSM state
module cube_color_controller
  import qbert_pkg::*;
#(
  parameter int          N_CUBE     = N_CUBE_DEF,
  parameter int unsigned WIN_CYCLES = 33_000_000,
  parameter int unsigned FLASH_DIV  = 4_125_000
) (
  input  logic              CLK_33,
  input  logic              reset,
  input  logic              e_start_qb,
  input  logic              e_pause_qb,
  input  logic              e_mode,
  input  logic              done_move,
  input  logic [N_CUBE-1:0] position_qb,
  output logic [N_CUBE-1:0] color_state,
  output logic [CNT_W-1:0]  n_colored,
  output logic              level_win,
  output logic              flash,
  output logic              bad_pos,
  output logic [2:0]        ctrl_state
);

  ctrl_state_t       state, state_next;
  logic [N_CUBE-1:0] pos_q, pos_next;
  logic [N_CUBE-1:0] color_next;
  logic [CNT_W-1:0]  n_next;
  logic              level_win_next, flash_next, bad_pos_next;
  logic [31:0]       hold_cnt, hold_next;
  logic [31:0]       div_cnt, div_next;

  logic pos_onehot, pos_zero;
  logic hit;

  onehot_check #(.N(N_CUBE)) u_onehot_check (
    .vec       (pos_q),
    .is_onehot (pos_onehot),
    .is_zero   (pos_zero)
  );

  // Landed cube is already in the target colour.
  assign hit        = |(color_state & pos_q);
  assign ctrl_state = state;

  always_comb begin
    state_next     = state;
    pos_next       = pos_q;
    color_next     = color_state;
    n_next         = n_colored;
    level_win_next = 1'b0;
    bad_pos_next   = 1'b0;
    flash_next     = flash;
    hold_next      = hold_cnt;
    div_next       = div_cnt;

    case (state)
      IDLE: begin
        if (e_start_qb) begin
          color_next = '0;
          n_next     = '0;
          state_next = PLAY;
        end
      end

      PLAY: begin
        // Restart wins over a simultaneous landing.
        if (e_start_qb) begin
          color_next = '0;
          n_next     = '0;
        end else if (done_move && !e_pause_qb) begin
          pos_next   = position_qb;
          state_next = EVAL;
        end
      end

      EVAL: begin
        state_next = CHECK;
        if (pos_zero || !pos_onehot) begin
          bad_pos_next = 1'b1;
        end else if (!e_mode) begin
          if (!hit) begin
            color_next = color_state | pos_q;
            n_next     = n_colored + CNT_W'(1);
          end
        end else if (hit) begin
          color_next = color_state & ~pos_q;
          n_next     = n_colored - CNT_W'(1);
        end else begin
          color_next = color_state | pos_q;
          n_next     = n_colored + CNT_W'(1);
        end
      end

      CHECK: begin
        if (n_colored == CNT_W'(N_CUBE)) begin
          state_next     = WIN;
          level_win_next = 1'b1;
          // Flash starts lit and runs off fresh counters.
          flash_next     = 1'b1;
          hold_next      = '0;
          div_next       = '0;
        end else begin
          state_next = PLAY;
        end
      end

      WIN: begin
        if (!e_pause_qb) begin
          if (hold_cnt == 32'(WIN_CYCLES - 1)) begin
            // Drop flash on the way out so it is never lit outside WIN.
            state_next = CLEAR;
            flash_next = 1'b0;
            hold_next  = '0;
            div_next   = '0;
          end else begin
            hold_next = hold_cnt + 32'd1;
            if (div_cnt == 32'(FLASH_DIV - 1)) begin
              div_next   = '0;
              flash_next = ~flash;
            end else begin
              div_next = div_cnt + 32'd1;
            end
          end
        end
      end

      CLEAR: begin
        color_next = '0;
        n_next     = '0;
        flash_next = 1'b0;
        hold_next  = '0;
        div_next   = '0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_33 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pos_q       <= '0;
      color_state <= '0;
      n_colored   <= '0;
      level_win   <= 1'b0;
      flash       <= 1'b0;
      bad_pos     <= 1'b0;
      hold_cnt    <= '0;
      div_cnt     <= '0;
    end else begin
      state       <= state_next;
      pos_q       <= pos_next;
      color_state <= color_next;
      n_colored   <= n_next;
      level_win   <= level_win_next;
      flash       <= flash_next;
      bad_pos     <= bad_pos_next;
      hold_cnt    <= hold_next;
      div_cnt     <= div_next;
    end
  end

endmodule

// File: tb/tb_cube_color_controller.sv
// Testbench for cube_color_controller with a short WIN window (20 cycles,
// flash half-period 4). Landing results are predicted by a small model and
// queued when the landing is driven, then popped when the DUT shows them.
module tb_cube_color_controller;

  localparam int N = 28;

  logic          clk = 1'b0;
  logic          reset;
  logic          e_start_qb, e_pause_qb, e_mode, done_move;
  logic [N-1:0]  position_qb;
  logic [N-1:0]  color_state;
  logic [4:0]    n_colored;
  logic          level_win, flash, bad_pos;
  logic [2:0]    ctrl_state;

  cube_color_controller #(
    .N_CUBE     (N),
    .WIN_CYCLES (20),
    .FLASH_DIV  (4)
  ) dut (
    .CLK_33      (clk),
    .reset       (reset),
    .e_start_qb  (e_start_qb),
    .e_pause_qb  (e_pause_qb),
    .e_mode      (e_mode),
    .done_move   (done_move),
    .position_qb (position_qb),
    .color_state (color_state),
    .n_colored   (n_colored),
    .level_win   (level_win),
    .flash       (flash),
    .bad_pos     (bad_pos),
    .ctrl_state  (ctrl_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] color;
    logic [4:0]   cnt;
    logic         bad;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] m_color;
  logic [4:0]   m_count;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One landing: predict, queue, drive, then compare at the output cycle.
  // Returns at the cycle after CHECK (PLAY, or the first WIN cycle).
  task automatic land(input logic [N-1:0] p);
    exp_t         e;
    logic [N-1:0] prev;
    prev  = m_color;
    e.bad = ($countones(p) != 1);
    if (!e.bad) begin
      if (!e_mode) begin
        if ((m_color & p) == '0) begin
          m_color = m_color | p;
          m_count = m_count + 5'd1;
        end
      end else if ((m_color & p) != '0) begin
        m_color = m_color & ~p;
        m_count = m_count - 5'd1;
      end else begin
        m_color = m_color | p;
        m_count = m_count + 5'd1;
      end
    end
    e.color = m_color;
    e.cnt   = m_count;
    e.bad   = e.bad;
    sb.push_back(e);
    done_move   = 1'b1;
    position_qb = p;
    @(negedge clk);
    done_move   = 1'b0;
    position_qb = '0;
    chk("eval_state", 32'(ctrl_state), 32'd2);
    chk("eval_color_unchanged", 32'(color_state), 32'(prev));
    @(negedge clk);
    e = sb.pop_front();
    chk("land_color", 32'(color_state), 32'(e.color));
    chk("land_count", 32'(n_colored), 32'(e.cnt));
    chk("land_bad_pos", 32'(bad_pos), 32'(e.bad));
    @(negedge clk);
  endtask

  task automatic start_level();
    e_start_qb = 1'b1;
    @(negedge clk);
    e_start_qb = 1'b0;
    m_color = '0;
    m_count = '0;
    chk("start_state", 32'(ctrl_state), 32'd1);
    chk("start_color", 32'(color_state), 32'd0);
  endtask

  task automatic fill_all();
    for (int i = 0; i < N; i++) begin
      land(N'(1) << i);
      if (i < N - 1) chk("fill_state_play", 32'(ctrl_state), 32'd1);
    end
    chk("win_entry_state", 32'(ctrl_state), 32'd4);
    chk("level_win_pulse", 32'(level_win), 32'd1);
  endtask

  initial begin
    int  h, fc;
    logic fl;
    bit  done;

    reset = 1'b1; e_start_qb = 1'b0; e_pause_qb = 1'b0; e_mode = 1'b0;
    done_move = 1'b0; position_qb = '0;
    m_color = '0; m_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_color", 32'(color_state), 32'd0);
    chk("rst_count", 32'(n_colored), 32'd0);
    chk("rst_level_win", 32'(level_win), 32'd0);
    chk("rst_flash", 32'(flash), 32'd0);
    chk("rst_bad_pos", 32'(bad_pos), 32'd0);
    chk("rst_state", 32'(ctrl_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", 32'(ctrl_state), 32'd0);

    start_level();

    // Mode 0: colour cube 0, then land on it again.
    land(28'h1);
    land(28'h1);
    // Mode 1: toggle cube 5 on, then off.
    e_mode = 1'b1;
    land(28'h20);
    land(28'h20);
    e_mode = 1'b0;
    // Invalid positions.
    land(28'h0);
    land(28'h3);

    // Landing while paused is dropped.
    e_pause_qb = 1'b1;
    done_move = 1'b1; position_qb = 28'h80;
    @(negedge clk);
    done_move = 1'b0; position_qb = '0;
    repeat (2) @(negedge clk);
    chk("pause_state", 32'(ctrl_state), 32'd1);
    chk("pause_color", 32'(color_state), 32'(m_color));
    chk("pause_count", 32'(n_colored), 32'(m_count));
    e_pause_qb = 1'b0;

    // Restart together with a landing: only the clear happens.
    e_start_qb = 1'b1; done_move = 1'b1; position_qb = 28'h200;
    @(negedge clk);
    e_start_qb = 1'b0; done_move = 1'b0; position_qb = '0;
    m_color = '0; m_count = '0;
    chk("start_done_state", 32'(ctrl_state), 32'd1);
    chk("start_done_color", 32'(color_state), 32'd0);
    chk("start_done_count", 32'(n_colored), 32'd0);

    // Complete the level and follow the WIN flash, with a pause inside.
    fill_all();
    h = 0; fc = 0; fl = 1'b1; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      chk("win_state", 32'(ctrl_state), 32'd4);
      chk("win_flash", 32'(flash), 32'(fl));
      if (cyc > 0) chk("win_level_win_low", 32'(level_win), 32'd0);
      e_pause_qb = (cyc >= 6 && cyc < 11);
      if (!e_pause_qb) begin
        if (h == 19) done = 1'b1;
        else h++;
        if (fc == 3) begin
          fc = 0;
          fl = ~fl;
        end else begin
          fc++;
        end
      end
      @(negedge clk);
    end
    e_pause_qb = 1'b0;
    chk("win_exit_reached", 32'(done), 32'd1);
    chk("clear_state", 32'(ctrl_state), 32'd5);
    chk("clear_flash", 32'(flash), 32'd0);
    @(negedge clk);
    chk("post_win_state", 32'(ctrl_state), 32'd0);
    chk("post_win_color", 32'(color_state), 32'd0);
    chk("post_win_count", 32'(n_colored), 32'd0);

    // Reset asserted in WIN with the hold counter at 10.
    start_level();
    fill_all();
    repeat (10) @(negedge clk);
    chk("pre_reset_state", 32'(ctrl_state), 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_color", 32'(color_state), 32'd0);
    chk("async_rst_count", 32'(n_colored), 32'd0);
    chk("async_rst_flash", 32'(flash), 32'd0);
    chk("async_rst_state", 32'(ctrl_state), 32'd0);
    @(negedge clk);
    chk("rst_win_level_win", 32'(level_win), 32'd0);
    chk("rst_win_bad_pos", 32'(bad_pos), 32'd0);
    chk("rst_win_state", 32'(ctrl_state), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("after_rst_idle", 32'(ctrl_state), 32'd0);
    chk("after_rst_flash", 32'(flash), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
